// File: rtl/intc_if.sv
// Bridge-side register bus for the interrupt controller: word select, write strobe and data.
// rdata is combinational from the slave. There is no backpressure; every access completes in its own cycle.
interface intc_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/intc.sv
// Edge-latching interrupt controller: pending/mask/GIE, fixed priority (bit 0 highest), one request per handler.
// IntReq rises 2 edges after a sampled edge. There is no backpressure; writes, EXLSet and EXLClr take effect in their cycle.
module intc #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] dev_irq,
  intc_if.slave            bus,
  input  logic             EXLSet,
  input  logic             EXLClr,
  output logic             IntReq
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pend_q, mask_q, irq_prev_q;
  logic             gie_q;
  logic [2:0]       cur_id_q;
  logic             cur_valid_q;

  logic [N_SRC-1:0] rise, active, w1c, ack_clr, pend_d;
  logic             any_act, ack, exc_entry;
  logic [2:0]       id;

  assign rise    = dev_irq & ~irq_prev_q;
  assign active  = pend_q & mask_q;
  assign any_act = gie_q & (|active);

  // Scanning downward leaves the lowest set index, which has the highest priority.
  always_comb begin
    id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) id = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    ack       = 1'b0;
    exc_entry = 1'b0;
    case (state_q)
      IDLE: begin
        if (EXLSet) begin
          state_d   = SVC;
          exc_entry = 1'b1;
        end else if (any_act) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (EXLSet) begin
          state_d = SVC;
          ack     = 1'b1;
        end else if (!any_act) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (EXLClr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack && (id == 3'(i));
    end
  end

  assign w1c = (bus.we && bus.addr == 2'd0) ? bus.wdata[N_SRC-1:0] : '0;
  // A rise in the same cycle as a clear keeps the bit set.
  assign pend_d = (pend_q & ~(w1c | ack_clr)) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      IntReq      <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      gie_q       <= 1'b0;
      irq_prev_q  <= '0;
      cur_id_q    <= 3'd0;
      cur_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      IntReq     <= (state_d == REQ);
      pend_q     <= pend_d;
      irq_prev_q <= dev_irq;
      if (bus.we && bus.addr == 2'd1) mask_q <= bus.wdata[N_SRC-1:0];
      if (bus.we && bus.addr == 2'd2) gie_q  <= bus.wdata[0];
      if (ack) begin
        cur_id_q    <= id;
        cur_valid_q <= 1'b1;
      end else if (exc_entry) begin
        cur_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0: bus.rdata[N_SRC-1:0] = pend_q;
      2'd1: bus.rdata[N_SRC-1:0] = mask_q;
      2'd2: bus.rdata[0]         = gie_q;
      default: begin
        bus.rdata[31]  = cur_valid_q;
        bus.rdata[2:0] = cur_id_q;
      end
    endcase
  end

endmodule

// File: tb/tb_intc.sv
// Directed plus random stimulus for intc, checked against a cycle-level behavioural model.
module tb_intc;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] dev_irq = '0;
  logic         EXLSet = 1'b0;
  logic         EXLClr = 1'b0;
  logic         IntReq;

  intc_if bus ();

  intc #(.N_SRC(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .dev_irq (dev_irq),
    .bus     (bus),
    .EXLSet  (EXLSet),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic         m_gie, m_req, m_svc, m_cur_valid;
  logic [2:0]   m_cur_id;

  task automatic m_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 1'b0;
    m_req = 1'b0; m_svc = 1'b0; m_cur_valid = 1'b0; m_cur_id = 3'd0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0] = m_pend;
      2'd1: r[N-1:0] = m_mask;
      2'd2: r[0]     = m_gie;
      default: begin r[31] = m_cur_valid; r[2:0] = m_cur_id; end
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] irq, input logic [1:0] a, input logic w,
                            input logic [31:0] d, input logic s, input logic c);
    logic [N-1:0] act, rise, clr;
    logic         anyv, found;
    int           idv;
    act  = m_pend & m_mask;
    anyv = m_gie && (act != '0);
    idv = 0; found = 1'b0;
    for (int i = 0; i < N; i++) if (!found && act[i]) begin idv = i; found = 1'b1; end
    rise = irq & ~m_prev;
    clr  = (w && a == 2'd0) ? d[N-1:0] : '0;
    if (m_svc) begin
      if (c) m_svc = 1'b0;
    end else if (s) begin
      if (m_req) begin
        m_cur_id = 3'(idv); m_cur_valid = 1'b1; clr[idv] = 1'b1;
      end else begin
        m_cur_valid = 1'b0;
      end
      m_svc = 1'b1; m_req = 1'b0;
    end else begin
      m_req = anyv;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (w && a == 2'd1) m_mask = d[N-1:0];
    if (w && a == 2'd2) m_gie = d[0];
    m_prev = irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] irq, input logic [1:0] a, input logic w,
                      input logic [31:0] d, input logic s, input logic c);
    dev_irq = irq; bus.addr = a; bus.we = w; bus.wdata = d; EXLSet = s; EXLClr = c;
    #1;
    chk("rdata_model", bus.rdata, model_rd(a));
    @(posedge clk);
    model_edge(irq, a, w, d, s, c);
    #1;
    chk("intreq_model", {31'b0, IntReq}, {31'b0, m_req});
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a; bus.we = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic idle_step();
    step(dev_irq, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] ri;
    logic [1:0]   ra;
    logic         rw, rs, rc;
    logic [31:0]  rd_v;

    bus.addr = 2'd0; bus.we = 1'b0; bus.wdata = '0;
    m_reset();
    #12;
    chk("reset_intreq", {31'b0, IntReq}, 32'h0);
    rd("reset_pend", 2'd0, 32'h0);
    rd("reset_mask", 2'd1, 32'h0);
    rd("reset_ctrl", 2'd2, 32'h0);
    rd("reset_id",   2'd3, 32'h0);
    rst = 1'b0;

    // Enable sources 0..5 and GIE
    step('0, 2'd1, 1'b1, 32'h3F, 1'b0, 1'b0);
    step('0, 2'd2, 1'b1, 32'h1,  1'b0, 1'b0);

    // Single source, latency and acknowledge
    step(6'h04, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    chk("lat_edge1", {31'b0, IntReq}, 32'h0);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    chk("lat_edge2", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd3, 1'b0, 0, 1'b1, 1'b0);
    chk("ack_drop", {31'b0, IntReq}, 32'h0);
    rd("ack_id2", 2'd3, 32'h80000002);
    rd("ack_pend2", 2'd0, 32'h0);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);

    // Two simultaneous sources, priority
    step(6'h12, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    chk("prio_req", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);
    rd("prio_id1", 2'd3, 32'h80000001);
    rd("prio_pend", 2'd0, 32'h10);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);
    chk("eret_edge1", {31'b0, IntReq}, 32'h0);
    idle_step();
    chk("eret_edge2", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);
    rd("prio_id4", 2'd3, 32'h80000004);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);

    // Mask withdrawal while requesting
    step(6'h08, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    idle_step();
    chk("mask_req", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0);
    idle_step();
    chk("mask_withdraw", {31'b0, IntReq}, 32'h0);
    rd("mask_pend", 2'd0, 32'h08);
    step(6'h00, 2'd1, 1'b1, 32'h3F, 1'b0, 1'b0);
    idle_step();
    chk("mask_restore", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);

    // New edge while in handler
    step(6'h01, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    idle_step();
    chk("svc_noreq", {31'b0, IntReq}, 32'h0);
    rd("svc_pend", 2'd0, 32'h01);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);
    chk("svc_eret1", {31'b0, IntReq}, 32'h0);
    idle_step();
    chk("svc_eret2", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);
    rd("svc_id0", 2'd3, 32'h80000000);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);
    idle_step();
    chk("idle_quiet", {31'b0, IntReq}, 32'h0);

    // Synchronous exception from IDLE
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);
    rd("exc_id", 2'd3, 32'h00000000);
    step(6'h20, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    idle_step();
    chk("exc_noreq", {31'b0, IntReq}, 32'h0);
    rd("exc_pend", 2'd0, 32'h20);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);
    idle_step();
    chk("exc_after_eret", {31'b0, IntReq}, 32'h1);
    step(6'h00, 2'd0, 1'b0, 0, 1'b1, 1'b0);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b1);

    // W1C racing a new rise on the same bit
    step(6'h04, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    step(6'h00, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    step(6'h04, 2'd0, 1'b1, 32'h04, 1'b0, 1'b0);
    rd("w1c_race", 2'd0, 32'h04);
    idle_step();
    chk("w1c_req", {31'b0, IntReq}, 32'h1);

    // Asynchronous reset mid-request
    rst = 1'b1;
    #1;
    chk("arst_intreq", {31'b0, IntReq}, 32'h0);
    rd("arst_pend", 2'd0, 32'h0);
    rd("arst_mask", 2'd1, 32'h0);
    rd("arst_ctrl", 2'd2, 32'h0);
    rd("arst_id",   2'd3, 32'h0);
    m_reset();
    dev_irq = '0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ri = N'($urandom);
      ra = 2'($urandom_range(0, 3));
      rw = ($urandom_range(0, 4) == 0);
      rd_v = $urandom;
      if (ra == 2'd2) rd_v[0] = ($urandom_range(0, 3) != 0);
      if (ra == 2'd1) rd_v = rd_v | 32'h1;
      rs = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 3) == 0);
      step(ri, ra, rw, rd_v, rs, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
